// File: rtl/cr_osf_ob_arb_pkg.sv
// AXI4-Stream datapath bus types shared by the outbound arbiter and its users.
// tuser[0] marks start of frame, tuser[1] marks end of frame.
package cr_osf_ob_arb_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [1:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

// File: rtl/cr_osf_ob_arb.sv
// Outbound frame arbiter: grants whole frames from the data-TLV or CQE requester
// to the outbound FIFO, with fixed CQE priority or round-robin contention.
module cr_osf_ob_arb
    import cr_osf_ob_arb_pkg::*;
#(
    parameter bit CQE_PRIO = 1'b0,
    parameter int BEAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  axi4s_dp_bus_t     dat_in,
    output axi4s_dp_rdy_t     dat_out,
    input  axi4s_dp_bus_t     cqe_in,
    output axi4s_dp_rdy_t     cqe_out,
    output axi4s_dp_bus_t     ob_in,
    input  axi4s_dp_rdy_t     ob_in_rdy,
    output logic              arb_gnt_dat,
    output logic              arb_gnt_cqe,
    output logic              sof_err,
    output logic              frame_done,
    output logic [BEAT_W-1:0] frame_beats,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_DAT = 2'd1,
        ARB_GNT_CQE = 2'd2
    } arb_state_e;

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              last_gnt_cqe_r;
    logic [BEAT_W-1:0] beat_cnt_r;

    logic dat_req_s;
    logic cqe_req_s;
    logic dat_drop_s;
    logic cqe_drop_s;
    logic pick_cqe_s;
    logic grant_s;
    logic xfer_s;
    logic eof_s;

    function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
        return (v == {BEAT_W{1'b1}}) ? v : v + {{(BEAT_W-1){1'b0}}, 1'b1};
    endfunction

    assign dat_req_s  = dat_in.tvalid & dat_in.tuser[0];
    assign cqe_req_s  = cqe_in.tvalid & cqe_in.tuser[0];
    assign dat_drop_s = dat_in.tvalid & ~dat_in.tuser[0];
    assign cqe_drop_s = cqe_in.tvalid & ~cqe_in.tuser[0];
    // last_gnt resets to CQE, so the data port wins the first contention
    assign pick_cqe_s = CQE_PRIO ? 1'b1 : ~last_gnt_cqe_r;
    assign grant_s    = (state_r == ARB_IDLE) && (state_nxt_s != ARB_IDLE);
    assign xfer_s     = ob_in.tvalid & ob_in_rdy.tready;
    assign eof_s      = xfer_s & ob_in.tuser[1];
    assign arb_busy   = (state_r != ARB_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision: arbitrate only on SOF beats, release only on a transferred EOF
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (dat_req_s && cqe_req_s) begin
                    state_nxt_s = pick_cqe_s ? ARB_GNT_CQE : ARB_GNT_DAT;
                end else if (dat_req_s) begin
                    state_nxt_s = ARB_GNT_DAT;
                end else if (cqe_req_s) begin
                    state_nxt_s = ARB_GNT_CQE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GNT_DAT, ARB_GNT_CQE: begin
                if (eof_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Stream steering: idle drops stray non-SOF beats, grant states pass the bus through
    always_comb begin
        ob_in   = '0;
        dat_out = '0;
        cqe_out = '0;
        if (rst) begin
            ob_in   = '0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    dat_out.tready = dat_drop_s;
                    cqe_out.tready = cqe_drop_s;
                end
                ARB_GNT_DAT: begin
                    ob_in          = dat_in;
                    dat_out.tready = ob_in_rdy.tready;
                end
                ARB_GNT_CQE: begin
                    ob_in          = cqe_in;
                    cqe_out.tready = ob_in_rdy.tready;
                end
                default: ob_in = '0;
            endcase
        end
    end

    // Status pulses, beat counting and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_cqe_r <= 1'b1;
            beat_cnt_r     <= '0;
            frame_beats    <= '0;
            arb_gnt_dat    <= 1'b0;
            arb_gnt_cqe    <= 1'b0;
            sof_err        <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            arb_gnt_dat <= grant_s && (state_nxt_s == ARB_GNT_DAT);
            arb_gnt_cqe <= grant_s && (state_nxt_s == ARB_GNT_CQE);
            sof_err     <= (state_r == ARB_IDLE) && (dat_drop_s || cqe_drop_s);
            frame_done  <= eof_s;
            if (grant_s) begin
                beat_cnt_r <= '0;
            end else if (xfer_s) begin
                beat_cnt_r <= sat_inc(beat_cnt_r);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (eof_s) begin
                frame_beats    <= sat_inc(beat_cnt_r);
                last_gnt_cqe_r <= (state_r == ARB_GNT_CQE);
            end else begin
                frame_beats    <= frame_beats;
                last_gnt_cqe_r <= last_gnt_cqe_r;
            end
        end
    end

endmodule

// File: tb/tb_cr_osf_ob_arb.sv
// Scoreboard bench for cr_osf_ob_arb: a round-robin instance and a CQE-priority
// instance, exercised one at a time with directed frames.
module tb_cr_osf_ob_arb;
    import cr_osf_ob_arb_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    axi4s_dp_bus_t din [2];
    axi4s_dp_bus_t cin [2];
    axi4s_dp_bus_t ob  [2];
    axi4s_dp_rdy_t dr  [2];
    axi4s_dp_rdy_t cr  [2];
    axi4s_dp_rdy_t obr [2];
    logic          gd [2], gc [2], se [2], fd [2], busy [2];
    logic [15:0]   fb [2];

    int checks = 0;
    int errors = 0;
    logic [65:0] beat_q [$];
    logic [19:0] ev_q   [$];

    always #5 clk = ~clk;

    cr_osf_ob_arb #(.CQE_PRIO(1'b0), .BEAT_W(16)) u_rr (
        .clk(clk), .rst(rst), .dat_in(din[0]), .dat_out(dr[0]), .cqe_in(cin[0]),
        .cqe_out(cr[0]), .ob_in(ob[0]), .ob_in_rdy(obr[0]), .arb_gnt_dat(gd[0]),
        .arb_gnt_cqe(gc[0]), .sof_err(se[0]), .frame_done(fd[0]),
        .frame_beats(fb[0]), .arb_busy(busy[0]));

    cr_osf_ob_arb #(.CQE_PRIO(1'b1), .BEAT_W(16)) u_pr (
        .clk(clk), .rst(rst), .dat_in(din[1]), .dat_out(dr[1]), .cqe_in(cin[1]),
        .cqe_out(cr[1]), .ob_in(ob[1]), .ob_in_rdy(obr[1]), .arb_gnt_dat(gd[1]),
        .arb_gnt_cqe(gc[1]), .sof_err(se[1]), .frame_done(fd[1]),
        .frame_beats(fb[1]), .arb_busy(busy[1]));

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [1:0] u, input logic [63:0] d);
        beat_q.push_back({u, d});
    endtask

    task automatic push_ev(input logic g_d, input logic g_c, input logic s_e,
                           input logic f_d, input logic [15:0] f_b);
        ev_q.push_back({g_d, g_c, s_e, f_d, f_b});
    endtask

    task automatic set_bus(input int i, input bit cqe, input logic v,
                           input logic [1:0] u, input logic [63:0] d);
        axi4s_dp_bus_t b;
        b.tvalid = v;
        b.tuser  = u;
        b.tdata  = d;
        if (cqe) cin[i] = b;
        else     din[i] = b;
    endtask

    function automatic logic rdy(input int i, input bit cqe);
        return cqe ? cr[i].tready : dr[i].tready;
    endfunction

    // Wait (bounded) until the presented beat is accepted, then step past that edge
    task automatic wait_xfer(input int i, input bit cqe);
        bit ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (rdy(i, cqe)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("xfer_timeout", 66'(ok), 66'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input bit cqe, input int n, input logic [63:0] base);
        for (int k = 0; k < n; k++) begin
            set_bus(i, cqe, 1'b1, {(k == n - 1), (k == 0)}, base + 64'(k));
            wait_xfer(i, cqe);
        end
        set_bus(i, cqe, 1'b0, 2'b00, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare on every forwarded beat and every status pulse
    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin : mon
            logic [65:0] eb;
            logic [19:0] ee;
            if (!rst) begin
                if (ob[g].tvalid && obr[g].tready) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_beat", {ob[g].tuser, ob[g].tdata}, 66'h3_FFFF_FFFF_FFFF_FFFF);
                    end else begin
                        eb = beat_q.pop_front();
                        chk("ob_beat", {ob[g].tuser, ob[g].tdata}, eb);
                    end
                end
                if (gd[g] || gc[g] || se[g] || fd[g]) begin
                    if (ev_q.size() == 0) begin
                        chk("unexpected_pulse", 66'({gd[g], gc[g], se[g], fd[g], fb[g]}), 66'h0);
                    end else begin
                        ee = ev_q.pop_front();
                        chk("pulse_event", 66'({gd[g], gc[g], se[g], fd[g], fb[g]}), 66'(ee));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            cin[i] = '0;
            obr[i].tready = 1'b1;
        end
        // Reset with a stray non-SOF beat present: nothing may be accepted
        din[0] = '{tvalid: 1'b1, tuser: 2'b00, tdata: 64'h55};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dat_tready", 66'(dr[0].tready), 66'(0));
        chk("rst_ob_tvalid",  66'(ob[0].tvalid), 66'(0));
        chk("rst_busy",       66'(busy[0]),      66'(0));
        chk("rst_beats",      66'(fb[0]),        66'(0));
        chk("rst_pulses",     66'({gd[0], gc[0], se[0], fd[0]}), 66'(0));
        @(posedge clk);
        #1;
        din[0] = '0;
        rst = 1'b0;
        idle(2);

        // Round-robin contention after reset: data first, then CQE
        push_beat(2'b01, 64'hA0);
        push_beat(2'b10, 64'hA1);
        push_beat(2'b11, 64'hC0);
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        push_ev(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        fork
            send_frame(0, 1'b0, 2, 64'hA0);
            send_frame(0, 1'b1, 1, 64'hC0);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("rr_gnt_dat_cycle1", 66'(gd[0]), 66'(1));
                chk("rr_busy_cycle1",    66'(busy[0]), 66'(1));
                chk("rr_cqe_blocked",    66'(cr[0].tready), 66'(0));
            end
        join
        idle(4);

        // CQE priority: CQE wins, data held off through CQE EOF plus the idle cycle
        push_beat(2'b11, 64'hC0);
        push_beat(2'b01, 64'hA0);
        push_beat(2'b10, 64'hA1);
        push_ev(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
        fork
            send_frame(1, 1'b0, 2, 64'hA0);
            send_frame(1, 1'b1, 1, 64'hC0);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("pr_gnt_cqe_cycle1", 66'(gc[1]), 66'(1));
                chk("pr_dat_rdy_c1",     66'(dr[1].tready), 66'(0));
                @(posedge clk);
                @(negedge clk);
                chk("pr_dat_rdy_c2",     66'(dr[1].tready), 66'(0));
                @(posedge clk);
                @(negedge clk);
                chk("pr_dat_rdy_c3",     66'(dr[1].tready), 66'(1));
            end
        join
        idle(4);

        // 4-beat data frame with downstream ready toggling 1,0,1,0
        push_beat(2'b01, 64'hD0);
        push_beat(2'b00, 64'hD1);
        push_beat(2'b00, 64'hD2);
        push_beat(2'b10, 64'hD3);
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
        fork
            send_frame(0, 1'b0, 4, 64'hD0);
            begin
                for (int k = 0; k < 20; k++) begin
                    obr[0].tready = (k % 2 == 0);
                    @(posedge clk);
                    #1;
                end
                obr[0].tready = 1'b1;
            end
        join
        idle(3);

        // Non-SOF beat while idle is dropped with a delayed sof_err pulse
        push_ev(1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        set_bus(0, 1'b0, 1'b1, 2'b00, 64'hBAD);
        @(negedge clk);
        chk("drop_dat_tready", 66'(dr[0].tready), 66'(1));
        chk("drop_ob_tvalid",  66'(ob[0].tvalid), 66'(0));
        @(posedge clk);
        #1;
        set_bus(0, 1'b0, 1'b0, 2'b00, 64'h0);
        @(negedge clk);
        chk("drop_sof_err", 66'(se[0]), 66'(1));
        idle(3);

        // Simultaneous drops on both ports give a single pulse
        push_ev(1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        set_bus(0, 1'b0, 1'b1, 2'b10, 64'hB0);
        set_bus(0, 1'b1, 1'b1, 2'b00, 64'hB1);
        @(negedge clk);
        chk("drop2_tready", 66'({dr[0].tready, cr[0].tready}), 66'(2'b11));
        @(posedge clk);
        #1;
        set_bus(0, 1'b0, 1'b0, 2'b00, 64'h0);
        set_bus(0, 1'b1, 1'b0, 2'b00, 64'h0);
        idle(3);

        // Single-beat CQE frame
        push_beat(2'b11, 64'hE0);
        push_ev(1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        send_frame(0, 1'b1, 1, 64'hE0);
        @(negedge clk);
        chk("single_busy_idle", 66'(busy[0]), 66'(0));
        chk("single_beats",     66'(fb[0]),   66'(1));
        idle(3);

        // Reset after beat 2 abandons the frame without frame_done
        push_beat(2'b01, 64'hF0);
        push_beat(2'b00, 64'hF1);
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
        set_bus(0, 1'b0, 1'b1, 2'b01, 64'hF0);
        wait_xfer(0, 1'b0);
        set_bus(0, 1'b0, 1'b1, 2'b00, 64'hF1);
        wait_xfer(0, 1'b0);
        set_bus(0, 1'b0, 1'b1, 2'b00, 64'hF2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ob_tvalid", 66'(ob[0].tvalid), 66'(0));
        chk("mid_rst_tready",    66'(dr[0].tready), 66'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_busy",   66'(busy[0]), 66'(0));
        chk("mid_rst_beats",  66'(fb[0]),   66'(0));
        chk("mid_rst_pulses", 66'({gd[0], gc[0], se[0], fd[0]}), 66'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bus(0, 1'b0, 1'b0, 2'b00, 64'h0);
        idle(2);
        push_beat(2'b11, 64'hF8);
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        push_ev(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        send_frame(0, 1'b0, 1, 64'hF8);
        idle(4);

        chk("beat_q_drained", 66'(beat_q.size()), 66'(0));
        chk("ev_q_drained",   66'(ev_q.size()),   66'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
